// File: rtl/alu_issue_queue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_queue_if
// Bundles the three channels of the ALU issue queue:
//   in_*      : upstream operation offer (valid/ready, tag, opcode, operands)
//   alu_*     : head-entry operands to an external combinational ALU and its
//               result coming back in the same cycle
//   out_*     : held result towards downstream (valid/ready, tag, result, err)
//   occupancy : number of FIFO entries currently held
// Modports: slave = the queue itself, master = the environment around it.
// ---------------------------------------------------------------------------
interface alu_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic [3:0]       in_mode;
    logic [63:0]      in_a;
    logic [63:0]      in_b;

    logic [63:0]      alu_a;
    logic [63:0]      alu_b;
    logic [3:0]       alu_mode;
    logic [63:0]      alu_result;

    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [63:0]      out_result;
    logic             out_err;

    logic [OCC_W-1:0] occupancy;

    modport slave (
        input  in_valid, in_tag, in_mode, in_a, in_b, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_mode,
               out_valid, out_tag, out_result, out_err, occupancy
    );

    modport master (
        output in_valid, in_tag, in_mode, in_a, in_b, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_mode,
               out_valid, out_tag, out_result, out_err, occupancy
    );
endinterface

// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
// DEPTH-entry FIFO of ALU operations {tag, mode, a, b}. The head entry is
// presented to an external combinational ALU; when the one-entry result
// register is free (or being drained) the head is popped and the ALU result,
// its tag and an error flag are captured.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_issue_queue_if.slave (in_*, alu_*, out_*, occupancy)
// ---------------------------------------------------------------------------
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Entry storage: asynchronous read is needed because the head must reach
    // the ALU in the same cycle it becomes the head.
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [3:0]       mode_mem [DEPTH];
    logic [63:0]      a_mem    [DEPTH];
    logic [63:0]      b_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ready_en_q;   // keeps in_ready low until the first edge after reset

    logic             out_valid_q, out_valid_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [63:0]      out_result_q, out_result_d;
    logic             out_err_q, out_err_d;

    logic             empty;
    logic             push;
    logic             pop;
    logic [3:0]       head_mode;
    logic [63:0]      head_b;
    logic             head_err;

    assign empty        = (occ_q == '0);
    assign bus.in_ready = ready_en_q && (occ_q < OCC_W'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = !empty && (!out_valid_q || bus.out_ready);

    assign head_mode    = mode_mem[rd_ptr_q];
    assign head_b       = b_mem[rd_ptr_q];
    assign head_err     = (head_mode > 4'd8) ||
                          (((head_mode == 4'd3) || (head_mode == 4'd4)) && (head_b == 64'd0));

    // Stale storage contents must never leak to the ALU when nothing is queued.
    assign bus.alu_a    = empty ? 64'd0 : a_mem[rd_ptr_q];
    assign bus.alu_b    = empty ? 64'd0 : head_b;
    assign bus.alu_mode = empty ? 4'd0  : head_mode;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_tag    = out_tag_q;
    assign bus.out_result = out_result_q;
    assign bus.out_err    = out_err_q;
    assign bus.occupancy  = occ_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        out_valid_d  = out_valid_q;
        out_tag_d    = out_tag_q;
        out_result_d = out_result_q;
        out_err_d    = out_err_q;

        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        if (pop) begin
            out_valid_d  = 1'b1;
            out_tag_d    = tag_mem[rd_ptr_q];
            out_result_d = bus.alu_result;
            out_err_d    = head_err;
        end else if (out_valid_q && bus.out_ready) begin
            // Drained with nothing to replace it: payload is left as-is.
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            ready_en_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_tag_q    <= '0;
            out_result_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            ready_en_q   <= 1'b1;
            out_valid_q  <= out_valid_d;
            out_tag_q    <= out_tag_d;
            out_result_q <= out_result_d;
            out_err_q    <= out_err_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q]  <= bus.in_tag;
            mode_mem[wr_ptr_q] <= bus.in_mode;
            a_mem[wr_ptr_q]    <= bus.in_a;
            b_mem[wr_ptr_q]    <= bus.in_b;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_queue
// Environment for alu_issue_queue: provides the combinational ALU, drives
// upstream/downstream handshakes and compares results against a reference
// model built from the accepted-operation list.
// ---------------------------------------------------------------------------
module tb_alu_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [3:0]       mode;
        logic [63:0]      a;
        logic [63:0]      b;
    } op_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [63:0]      res;
        logic             err;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   max_occ = 0;
    op_t  acc_q[$];
    res_t got_q[$];

    alu_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU.
    function automatic logic [63:0] alu_fn(logic [3:0] m, logic [63:0] a, logic [63:0] b);
        case (m)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a * b;
            4'd3:    return (b == 0) ? 64'd0 : a / b;
            4'd4:    return (b == 0) ? 64'd0 : a % b;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return (a > b) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_mode, bus.alu_a, bus.alu_b);

    // Reference: what the result of an accepted op must be.
    function automatic res_t ref_model(op_t op);
        res_t r;
        r.tag = op.tag;
        r.err = (op.mode > 8) || ((op.mode == 3 || op.mode == 4) && op.b == 0);
        if (r.err)             r.res = 64'd0;
        else if (op.mode == 0) r.res = op.a + op.b;
        else if (op.mode == 1) r.res = op.a - op.b;
        else if (op.mode == 2) r.res = op.a * op.b;
        else if (op.mode == 3) r.res = op.a / op.b;
        else if (op.mode == 4) r.res = op.a % op.b;
        else if (op.mode == 5) r.res = op.a & op.b;
        else if (op.mode == 6) r.res = op.a | op.b;
        else if (op.mode == 7) r.res = op.a ^ op.b;
        else                   r.res = {63'd0, op.a > op.b};
        return r;
    endfunction

    // Handshake monitor, sampled mid-cycle where everything is stable.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                acc_q.push_back(op_t'{bus.in_tag, bus.in_mode, bus.in_a, bus.in_b});
                $display("[%0t] accept tag=%0d mode=%0d a=%0h b=%0h", $time,
                         bus.in_tag, bus.in_mode, bus.in_a, bus.in_b);
            end
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(res_t'{bus.out_tag, bus.out_result, bus.out_err});
                $display("[%0t] result tag=%0d res=%0h err=%0b", $time,
                         bus.out_tag, bus.out_result, bus.out_err);
            end
            if (int'(bus.occupancy) > max_occ) max_occ = int'(bus.occupancy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op and hold it until accepted (bounded).
    task automatic push_op(input int tag, input int mode, input logic [63:0] a, input logic [63:0] b);
        bus.in_valid = 1'b1;
        bus.in_tag   = TAG_W'(tag);
        bus.in_mode  = 4'(mode);
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checks++; errors++;
        $display("FAIL push_timeout tag=%0d: in_ready never rose", tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.occupancy !== '0) begin errors++; $display("FAIL rst_occupancy got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_mode} !== '0) begin errors++; $display("FAIL rst_alu got=%0h/%0h/%0h exp=0", bus.alu_a, bus.alu_b, bus.alu_mode); end
        checks++; if ({bus.out_tag, bus.out_result, bus.out_err} !== '0) begin errors++; $display("FAIL rst_out_payload got=%0h/%0h/%0b exp=0", bus.out_tag, bus.out_result, bus.out_err); end
        #3 rst_n = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rel_in_ready_early got=%0b exp=0", bus.in_ready); end
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_tag    = 4'd3;
        bus.in_mode   = 4'd0;
        bus.in_a      = 64'd5;
        bus.in_b      = 64'd7;
        #1;
        checks++; if (bus.alu_a !== 64'd0) begin errors++; $display("FAIL single_no_bypass alu_a got=%0h exp=0", bus.alu_a); end
        step();
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd1) begin errors++; $display("FAIL single_queued out_valid=%0b occ=%0d exp 0/1", bus.out_valid, bus.occupancy); end
        checks++; if (bus.alu_a !== 64'd5 || bus.alu_b !== 64'd7) begin errors++; $display("FAIL single_head got a=%0h b=%0h exp 5/7", bus.alu_a, bus.alu_b); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 64'd12 || bus.out_tag !== 4'd3 || bus.out_err !== 1'b0)
            begin errors++; $display("FAIL single_result got v=%0b res=%0d tag=%0d err=%0b exp 1/12/3/0", bus.out_valid, bus.out_result, bus.out_tag, bus.out_err); end
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.out_tag !== 4'd3 || bus.out_result !== 64'd12)
            begin errors++; $display("FAIL single_drain got v=%0b tag=%0d res=%0d exp 0/3/12", bus.out_valid, bus.out_tag, bus.out_result); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int t = 0; t < 5; t++) push_op(t, 0, 64'(100 + t), 64'd1);
        #1;
        checks++; if (bus.occupancy !== 3'd4 || bus.in_ready !== 1'b0)
            begin errors++; $display("FAIL bp_full got occ=%0d in_ready=%0b exp 4/0", bus.occupancy, bus.in_ready); end
        step(); step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd0 || bus.out_result !== 64'd101)
            begin errors++; $display("FAIL bp_hold got v=%0b tag=%0d res=%0d exp 1/0/101", bus.out_valid, bus.out_tag, bus.out_result); end
        bus.out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== TAG_W'(t))
                begin errors++; $display("FAIL bp_drain[%0d] got v=%0b tag=%0d exp 1/%0d", t, bus.out_valid, bus.out_tag, t); end
            step();
        end
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== '0)
            begin errors++; $display("FAIL bp_empty got v=%0b occ=%0d exp 0/0", bus.out_valid, bus.occupancy); end
    endtask

    task automatic test_errors();
        logic [63:0] exp_res [3] = '{64'd0, 64'd0, 64'd1};
        logic        exp_err [3] = '{1'b1, 1'b1, 1'b0};
        int          modes   [3] = '{3, 9, 4};
        logic [63:0] as      [3] = '{64'd10, 64'd1, 64'd10};
        logic [63:0] bs      [3] = '{64'd0, 64'd1, 64'd3};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_op(10 + i, modes[i], as[i], bs[i]);
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp_res[i] || bus.out_err !== exp_err[i])
                begin errors++; $display("FAIL err_case[%0d] got v=%0b res=%0h err=%0b exp 1/%0h/%0b", i, bus.out_valid, bus.out_result, bus.out_err, exp_res[i], exp_err[i]); end
            step();
        end
    endtask

    task automatic test_stream();
        int cyc = 0;
        int bad = 0;
        acc_q.delete();
        got_q.delete();
        max_occ = 0;
        while ((acc_q.size() < 20 || got_q.size() < 20) && cyc < 3000) begin
            if (acc_q.size() < 20 && ($urandom % 2) == 1) begin
                bus.in_valid = 1'b1;
                bus.in_tag   = TAG_W'($urandom);
                bus.in_mode  = 4'($urandom_range(0, 10));
                bus.in_a     = {$urandom, $urandom};
                bus.in_b     = (($urandom % 4) == 0) ? 64'd0 : 64'($urandom_range(1, 1000));
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'($urandom % 2);
            step();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++; if (acc_q.size() != 20 || got_q.size() != 20)
            begin errors++; $display("FAIL stream_count got acc=%0d res=%0d exp 20/20", acc_q.size(), got_q.size()); end
        checks++; if (max_occ > DEPTH) begin errors++; $display("FAIL stream_max_occ got=%0d exp<=%0d", max_occ, DEPTH); end
        for (int i = 0; i < 20 && i < got_q.size() && i < acc_q.size(); i++) begin
            res_t e;
            e = ref_model(acc_q[i]);
            if (got_q[i].tag !== e.tag || got_q[i].res !== e.res || got_q[i].err !== e.err) begin
                bad++;
                $display("FAIL stream_result[%0d] got tag=%0d res=%0h err=%0b exp tag=%0d res=%0h err=%0b",
                         i, got_q[i].tag, got_q[i].res, got_q[i].err, e.tag, e.res, e.err);
            end
        end
        checks++; if (bad != 0) errors++;
    endtask

    task automatic test_reset_midflight();
        int leaked = 0;
        bus.out_ready = 1'b0;
        for (int t = 0; t < 3; t++) push_op(t, 0, 64'd1, 64'd1);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.occupancy !== 3'd2)
            begin errors++; $display("FAIL mid_pre got v=%0b occ=%0d exp 1/2", bus.out_valid, bus.occupancy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== '0 || bus.in_ready !== 1'b0 || bus.alu_mode !== 4'd0)
            begin errors++; $display("FAIL mid_async got v=%0b occ=%0d rdy=%0b mode=%0d exp 0/0/0/0", bus.out_valid, bus.occupancy, bus.in_ready, bus.alu_mode); end
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        step();
        acc_q.delete();
        got_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid !== 1'b0) leaked++;
            step();
        end
        checks++; if (leaked != 0) begin errors++; $display("FAIL mid_leak got %0d cycles valid exp 0", leaked); end
        push_op(7, 8, 64'd9, 64'd2);
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 64'd1 || bus.out_tag !== 4'd7 || bus.out_err !== 1'b0)
            begin errors++; $display("FAIL mid_new got v=%0b res=%0d tag=%0d err=%0b exp 1/1/7/0", bus.out_valid, bus.out_result, bus.out_tag, bus.out_err); end
        step();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_tag    = '0;
        bus.in_mode   = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_errors();
        test_stream();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
